// File: rtl/mod_exp_lsb_param_pkg.sv
// Shared types and constants for the LSB-first Montgomery modular exponentiator.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int W_MIN = 32'sd8;
  localparam int W_MAX = 32'sd1024;

  // Counter width able to hold the value W itself.
  function automatic int cw_of(input int w);
    return $clog2(w + 32'sd1);
  endfunction

  // Cycles from the acceptance edge to the valid pulse when k exponent bits are processed.
  function automatic int lat(input int w, input int k);
    return w + k * (w + 32'sd3) + 32'sd1;
  endfunction

endpackage

// File: rtl/mod_exp_lsb_param_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-W mod n.
// done pulses W+2 cycles after start is sampled; start is ignored while busy.
module mont_mul
  import mod_exp_pkg::*;
#(
  parameter int W  = 256,
  parameter int CW = cw_of(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         done,
  output logic [W-1:0] result
);

  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);

  logic [W-1:0]  a_r, b_r, n_r, result_r;
  logic [W+1:0]  m_r, b_ext_s, n_ext_s, add_b_s, add_n_s, m_next_s, fin_s;
  logic [CW-1:0] cnt_r;
  logic          busy_r, fin_r, done_r;

  // One reduction step and the final conditional subtract.
  always_comb begin
    b_ext_s  = {2'b00, b_r};
    n_ext_s  = {2'b00, n_r};
    add_b_s  = a_r[0] ? (m_r + b_ext_s) : m_r;
    add_n_s  = add_b_s[0] ? (add_b_s + n_ext_s) : add_b_s;
    m_next_s = add_n_s >> 32'd1;
    fin_s    = (m_r >= n_ext_s) ? (m_r - n_ext_s) : m_r;
  end

  // Operand capture, W iterations, one subtract cycle, then the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      n_r      <= {W{1'b0}};
      m_r      <= {(W+2){1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      fin_r    <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {W{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (start && !busy_r && !fin_r) begin
        a_r    <= a;
        b_r    <= b;
        n_r    <= n;
        m_r    <= {(W+2){1'b0}};
        cnt_r  <= {CW{1'b0}};
        busy_r <= 1'b1;
      end else if (busy_r) begin
        m_r   <= m_next_s;
        a_r   <= a_r >> 32'd1;
        cnt_r <= cnt_r + ONE_CW;
        if (cnt_r == LAST_CNT) begin
          busy_r <= 1'b0;
          fin_r  <= 1'b1;
        end
      end else if (fin_r) begin
        result_r <= W'(fin_s);
        fin_r    <= 1'b0;
        done_r   <= 1'b1;
      end
    end
  end

  assign done   = done_r;
  assign result = result_r;

endmodule

// File: rtl/mod_exp_lsb_param.sv
// Right-to-left modular exponentiator S_out = M_i^d_i mod N_i in the Montgomery domain.
// Optional MOD_EXP_EARLY_EXIT_EN stops after the highest set exponent bit (not constant-time).
module mod_exp_lsb_param
  import mod_exp_pkg::*;
#(
  parameter int W  = 256,
  parameter int CW = cw_of(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] M_i,
  input  logic [W-1:0] N_i,
  input  logic [W-1:0] d_i,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] S_out
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
  localparam logic [CW-1:0] ONE_CW   = CW'(1);
  localparam logic [W-1:0]  ONE_W    = W'(1);

  state_e        state_r, state_s;
  logic [W-1:0]  t_r, s_r, n_r, d_r, s_out_r, res_a_s, res_b_s;
  logic [W:0]    dbl_s, n_ext_s, prep_s;
  logic [CW-1:0] prep_cnt_r, bit_idx_r, next_idx_s;
  logic          ready_r, valid_r, d_bit_s, mul_start_s;
  logic          done_a_s, done_b_s, mul_done_s, exit_prep_s, exit_wait_s;

  // Doubling step for T -> M*2^W mod N, current exponent bit and iteration advance.
  always_comb begin
    dbl_s      = {t_r, 1'b0};
    n_ext_s    = {1'b0, n_r};
    prep_s     = (dbl_s >= n_ext_s) ? (dbl_s - n_ext_s) : dbl_s;
    next_idx_s = bit_idx_r + ONE_CW;
    d_bit_s    = |(d_r & (ONE_W << bit_idx_r));
    mul_done_s = done_a_s & done_b_s;
  end

`ifdef MOD_EXP_EARLY_EXIT_EN
  // Skip the remaining iterations once no set exponent bits are left.
  always_comb begin
    exit_prep_s = (d_r == {W{1'b0}});
    exit_wait_s = ((d_r >> next_idx_s) == {W{1'b0}});
  end
`else
  // Constant-time: every exponent bit is always processed.
  always_comb begin
    exit_prep_s = 1'b0;
    exit_wait_s = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && ready_r) state_s = PREP;
        else                  state_s = IDLE;
      end
      PREP: begin
        if (prep_cnt_r == LAST_IDX) state_s = exit_prep_s ? DONE : ISSUE;
        else                        state_s = PREP;
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (mul_done_s) begin
          if ((bit_idx_r == LAST_IDX) || exit_wait_s) state_s = DONE;
          else                                        state_s = ISSUE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Multiplier launch strobe.
  always_comb begin
    case (state_r)
      ISSUE:   mul_start_s = 1'b1;
      default: mul_start_s = 1'b0;
    endcase
  end

  // Operand latches, exponentiation registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r        <= {W{1'b0}};
      s_r        <= {W{1'b0}};
      n_r        <= {W{1'b0}};
      d_r        <= {W{1'b0}};
      prep_cnt_r <= {CW{1'b0}};
      bit_idx_r  <= {CW{1'b0}};
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      s_out_r    <= {W{1'b0}};
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && ready_r) begin
            t_r        <= M_i;
            s_r        <= ONE_W;
            n_r        <= N_i;
            d_r        <= d_i;
            prep_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= {CW{1'b0}};
            ready_r    <= 1'b0;
          end
        end
        PREP: begin
          t_r        <= W'(prep_s);
          prep_cnt_r <= prep_cnt_r + ONE_CW;
        end
        WAIT: begin
          if (mul_done_s) begin
            t_r       <= res_b_s;
            s_r       <= d_bit_s ? res_a_s : s_r;
            bit_idx_r <= next_idx_s;
          end
        end
        DONE: begin
          s_out_r <= s_r;
          valid_r <= 1'b1;
          ready_r <= 1'b1;
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // S stays in the normal domain because T carries the Montgomery factor.
  mont_mul #(.W(W), .CW(CW)) u_mul_a (
    .clk(clk), .rst(rst), .start(mul_start_s),
    .a(s_r), .b(t_r), .n(n_r), .done(done_a_s), .result(res_a_s)
  );

  mont_mul #(.W(W), .CW(CW)) u_mul_b (
    .clk(clk), .rst(rst), .start(mul_start_s),
    .a(t_r), .b(t_r), .n(n_r), .done(done_b_s), .result(res_b_s)
  );

  assign ready = ready_r;
  assign valid = valid_r;
  assign S_out = s_out_r;

endmodule

// File: doc/mod_exp_lsb_param.md
Name: mod_exp_lsb_param

Overview:
- Parametrised right-to-left (LSB-first) modular exponentiator: S = M^d mod N for W-bit operands.
- Montgomery-domain datapath. Two parallel Montgomery multipliers: one square, one conditional multiply.
- Adds a registered start/ready/valid handshake, synchronous reset and a deterministic cycle count.
- Sits between the RSA key/message registers and the result-readout logic of the crypto core.

Parameters:
- W, 256, operand width in bits (M, N, d, S); legal range 8..1024.
- CW, $clog2(W+1), width of the exponent-bit counter and the prep counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only while ready=1.
- M_i  in  W  message; requirement M_i < N_i.
- N_i  in  W  modulus; must be odd and > 1.
- d_i  in  W  exponent.
- ready  out  1  high in IDLE; operation accepted when start & ready.
- valid  out  1  one-cycle pulse; S_out is new in that cycle.
- S_out  out  W  result; holds its value until the next valid.

Behaviour:
- Reset values: ready=1, valid=0, S_out=0, state=IDLE, counters=0.
- rst has priority over every other event, including mid-operation. The block returns to IDLE in the next cycle, the result is discarded and valid is not pulsed.
- Acceptance cycle (cycle 0): start & ready sampled. M_i, N_i, d_i are latched into internal registers, T<=M, the state goes to PREP and ready falls next cycle.
- Input changes after cycle 0 have no effect.
- start while ready=0 is ignored, not queued.
- PREP, exactly W cycles: T <= 2T; if (2T >= N) T <= 2T - N. The compare/subtract uses W+1-bit arithmetic. The result is T = M*2^W mod N and S <= 1.
- ISSUE, 1 cycle: pulse start to both mont_mul instances. Multiplier A computes (S,T); multiplier B computes (T,T).
- WAIT: wait for done from the instances; both have identical fixed latency.
- On the done cycle:
  - T <= B.result.
  - S <= A.result if d[i]=1, else S unchanged.
  - i <= i+1.
  - If i == W-1, go to DONE; else go to ISSUE.
- Each exponent bit costs exactly W+3 cycles.
- DONE, 1 cycle: S_out <= S, valid=1, ready=1 next cycle, state goes to IDLE.
- Latency from the acceptance edge to the valid pulse is W + W*(W+3) + 1 cycles (W=8: 97).
- A new start may be accepted in the cycle after valid.
- Correctness: S starts in the normal domain and T in the Montgomery domain, so MM(S,T) keeps S in the normal domain. No final conversion is needed.
- Boundaries:
  - d=0 gives S_out=1.
  - M=0 with d>0 gives 0.
  - M >= N or even N: S_out is unspecified, but the FSM still completes with the normal latency and never hangs.

Optional Feature:
- Macro MOD_EXP_EARLY_EXIT_EN.
- When defined: on entry to ISSUE, if (d >> i) == 0 the block goes directly to DONE. Latency becomes W + k*(W+3) + 1, where k = index of the highest set bit + 1 (k=0 for d=0). Results are identical.
- When undefined: always W iterations, constant-time execution for side-channel resistance.

Decomposition:
- Package mod_exp_pkg holds:
  - state enum (IDLE, PREP, ISSUE, WAIT, DONE);
  - localparam helper for CW;
  - latency constant function lat(W,k) used by the bench.
- Sub-module mont_mul (parameter W):
  - Ports: clk, rst, start, a, b, n, done, result.
  - Bit-serial radix-2 algorithm: for W cycles, m += a[j]*b; if m odd, m += n; m >>= 1. Then one cycle of final subtract if m >= n.
  - done pulses W+2 cycles after start is sampled; m uses W+2 bits.

Test Plan:
- W=8, M=5, d=3, N=13 -> valid after exactly 97 cycles, S_out=8; ready low throughout.
- W=8, d=0, M=7, N=11 -> S_out=1. With MOD_EXP_EARLY_EXIT_EN, latency is 9 cycles; without it, 97.
- W=16, M=2, d=10, N=1001 -> S_out=23. Back-to-back second op M=3, d=4, N=1001, with start in the cycle after valid -> S_out=81.
- W=8, M=5, d=3, N=13: assert rst at cycle 40 -> the next cycle shows ready=1, valid=0, S_out=0; no valid pulse follows. A fresh start yields 8.
- start held high during a busy period, with changed M_i/d_i -> ignored; the result matches the originally latched operands.
- W=256 random odd N, M<N, random d (1000 runs) vs. a reference model -> all match; the latency equals lat(W,k) in both macro settings.
